// File: rtl/apu_pkg.sv
// Shared APU constants: length-counter lookup table and the triangle
// sequencer output table.
package apu_pkg;

   typedef logic [4:0] tri_step_t;

   localparam logic [7:0] LENGTH_TABLE [0:31] = '{
      8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
      8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
      8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
      8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
   };

   // Falling ramp 15..0 followed by rising ramp 0..15.
   localparam logic [3:0] TRI_SEQ [0:31] = '{
      4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9,  4'd8,
      4'd7,  4'd6,  4'd5,  4'd4,  4'd3,  4'd2,  4'd1,  4'd0,
      4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
      4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
   };

endpackage

// File: rtl/apu_frame_divider.sv
// Local frame sequencer: one-cycle quarter tick every QUARTER_FRAME_CYCLES
// clocks, with every second quarter tick also flagged as a half tick.
module apu_frame_divider #(
   parameter int QUARTER_FRAME_CYCLES = 7457
) (
   input  logic clk,
   input  logic rst_n,
   output logic quarter,
   output logic half
);

   localparam int CW = (QUARTER_FRAME_CYCLES > 2) ? $clog2(QUARTER_FRAME_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(QUARTER_FRAME_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic          half_phase;

   assign quarter = (cnt == LAST);
   assign half    = quarter & half_phase;

   // Free-running divider; half_phase alternates on each quarter tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         half_phase <= 1'b0;
      end else if (quarter) begin
         cnt        <= '0;
         half_phase <= ~half_phase;
      end else begin
         cnt        <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/triangle_channel.sv
// Triangle voice: period timer, 32-step sequencer, linear and length counters.
// Optional build macro: TRIANGLE_ULTRASONIC_MUTE_EN (freeze the sequencer
// when the period is below 2).
module triangle_channel
   import apu_pkg::*;
#(
   parameter int QUARTER_FRAME_CYCLES = 7457
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] reg4008,
   input  logic [7:0] reg400A,
   input  logic [7:0] reg400B,
   output logic [3:0] wave
);

   logic [10:0] period;
   logic [10:0] timer;
   tri_step_t   step;
   tri_step_t   step_next;
   logic [6:0]  linear;
   logic [7:0]  length;
   logic        reload;
   logic [7:0]  reg400b_p1;
   logic        first_p1;
   logic        write_evt;
   logic        quarter;
   logic        half;
   logic        period_ok;
   logic        advance;
   logic        ctrl;

   assign period    = {reg400B[2:0], reg400A};
   assign ctrl      = reg4008[7];
   assign write_evt = first_p1 | (reg400B != reg400b_p1);
   assign step_next = step + 5'd1;

`ifdef TRIANGLE_ULTRASONIC_MUTE_EN
   assign period_ok = (period >= 11'd2);
`else
   assign period_ok = 1'b1;
`endif

   assign advance = (timer == 11'd0) & (linear != 7'd0) & (length != 8'd0) & period_ok;

   apu_frame_divider #(
      .QUARTER_FRAME_CYCLES(QUARTER_FRAME_CYCLES)
   ) u_frame (
      .clk    (clk),
      .rst_n  (rst_n),
      .quarter(quarter),
      .half   (half)
   );

   // Previous-cycle copy of $400B; the first edge out of reset counts as a write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg400b_p1 <= 8'd0;
         first_p1   <= 1'b1;
      end else begin
         reg400b_p1 <= reg400B;
         first_p1   <= 1'b0;
      end
   end

   // Period timer reloads on zero; the sequencer steps on that same edge when gated on.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer <= 11'd0;
         step  <= '0;
         wave  <= 4'd15;
      end else begin
         if (timer == 11'd0) begin
            timer <= period;
         end else begin
            timer <= timer - 11'd1;
         end
         if (advance) begin
            step <= step_next;
            wave <= TRI_SEQ[step_next];
         end
      end
   end

   // Linear counter on quarter ticks; the tick sees the reload flag from before any same-cycle write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         linear <= 7'd0;
         reload <= 1'b1;
      end else begin
         if (quarter) begin
            if (reload) begin
               linear <= reg4008[6:0];
            end else if (linear != 7'd0) begin
               linear <= linear - 7'd1;
            end
         end
         if (write_evt) begin
            reload <= 1'b1;
         end else if (quarter && !ctrl) begin
            reload <= 1'b0;
         end
      end
   end

   // Length counter: a write load takes priority over a half-tick decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         length <= 8'd0;
      end else if (write_evt) begin
         length <= LENGTH_TABLE[reg400B[7:3]];
      end else if (half && !ctrl && (length != 8'd0)) begin
         length <= length - 8'd1;
      end
   end

endmodule

// File: tb/tb_triangle_channel.sv
// Bench for triangle_channel: directed table, corner sequences and random
// stimulus checked against a behavioural model.
module tb_triangle_channel;

   localparam int Q = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] reg4008;
   logic [7:0] reg400A;
   logic [7:0] reg400B;
   logic [3:0] wave;

   int checks = 0;
   int passed = 0;

   triangle_channel #(.QUARTER_FRAME_CYCLES(Q)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .reg4008(reg4008),
      .reg400A(reg400A),
      .reg400B(reg400B),
      .wave   (wave)
   );

   always #5 clk = ~clk;

   int lt [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                   12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

   // Behavioural model state
   int m_timer, m_stp, m_lin, m_len, m_reload, m_fcnt, m_qcnt, m_first, m_wave;
   logic [7:0] m_prev;

   function automatic int wave_of(input int s);
      return (s < 16) ? (15 - s) : (s - 16);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_timer = 0; m_stp = 0; m_lin = 0; m_len = 0; m_reload = 1;
      m_fcnt = 0; m_qcnt = 0; m_first = 1; m_prev = 8'd0; m_wave = 15;
   endtask

   task automatic model_edge();
      int p;
      bit wr, q, h, ctl, go;
      p   = int'({reg400B[2:0], reg400A});
      wr  = (m_first != 0) || (reg400B != m_prev);
      q   = (m_fcnt == Q - 1);
      h   = q && ((m_qcnt % 2) == 1);
      ctl = reg4008[7];
      go  = (m_timer == 0) && (m_lin != 0) && (m_len != 0);
`ifdef TRIANGLE_ULTRASONIC_MUTE_EN
      if (p < 2) go = 1'b0;
`endif
      if (m_timer == 0) m_timer = p; else m_timer = m_timer - 1;
      if (go) begin
         m_stp  = (m_stp + 1) % 32;
         m_wave = wave_of(m_stp);
      end
      if (q) begin
         if (m_reload != 0) m_lin = int'(reg4008[6:0]);
         else if (m_lin > 0) m_lin = m_lin - 1;
      end
      if (wr) m_reload = 1;
      else if (q && !ctl) m_reload = 0;
      if (wr) m_len = lt[reg400B[7:3]];
      else if (h && !ctl && m_len > 0) m_len = m_len - 1;
      m_fcnt = (m_fcnt + 1) % Q;
      if (q) m_qcnt++;
      m_prev  = reg400B;
      m_first = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge(); else model_reset();
      #1;
      chk("wave_vs_model", int'(wave), m_wave);
   endtask

   typedef struct {
      logic [7:0] r4008;
      logic [7:0] r400a;
      logic [7:0] r400b;
      int         ncyc;
      int         exp_wave;
      int         exp_lin;
      int         exp_len;
   } vec_t;

   vec_t tbl [18];

   initial begin
      // Each row: apply inputs, run ncyc edges, then check wave/linear/length.
      tbl[0]  = '{8'hC8, 8'h03, 8'h08,   1, 15,  0, 254};
      tbl[1]  = '{8'hC8, 8'h03, 8'h08,   3, 15, 72, 254};
      tbl[2]  = '{8'hC8, 8'h03, 8'h08,   1, 14, 72, 254};
      tbl[3]  = '{8'hC8, 8'h03, 8'h08,   3, 14, 72, 254};
      tbl[4]  = '{8'hC8, 8'h03, 8'h08,   1, 13, 72, 254};
      tbl[5]  = '{8'hC8, 8'h03, 8'h08,  56,  0, 72, 254};
      tbl[6]  = '{8'hC8, 8'h03, 8'h08,   4,  1, 72, 254};
      tbl[7]  = '{8'hC8, 8'h03, 8'h08,  60, 15, 72, 254};
      tbl[8]  = '{8'hC8, 8'h03, 8'h08,   4, 14, 72, 254};
      tbl[9]  = '{8'h48, 8'h03, 8'h08,   3, 14, 72, 253};
      tbl[10] = '{8'h48, 8'h03, 8'h08,   4, 13, 71, 253};
      tbl[11] = '{8'h48, 8'h03, 8'h08,   4, 12, 70, 252};
      tbl[12] = '{8'h48, 8'h03, 8'h08, 280,  6,  0, 217};
      tbl[13] = '{8'h48, 8'h03, 8'h08,   8,  6,  0, 216};
      tbl[14] = '{8'h48, 8'h03, 8'h18,   1,  6,  0,   2};
      tbl[15] = '{8'h48, 8'h03, 8'h18,   7,  5, 71,   1};
      tbl[16] = '{8'h48, 8'h03, 8'h18,   8,  3, 69,   0};
      tbl[17] = '{8'h48, 8'h03, 8'h18,  20,  3, 64,   0};

      rst_n   = 1'b0;
      reg4008 = 8'hC8;
      reg400A = 8'h03;
      reg400B = 8'h08;
      model_reset();
      tick();
      tick();
      chk("reset_wave", int'(wave), 15);
      chk("reset_step", int'(dut.step), 0);
      rst_n = 1'b1;

      for (int i = 0; i < 18; i++) begin
         reg4008 = tbl[i].r4008;
         reg400A = tbl[i].r400a;
         reg400B = tbl[i].r400b;
         repeat (tbl[i].ncyc) tick();
         chk($sformatf("row%0d_wave", i), int'(wave), tbl[i].exp_wave);
         chk($sformatf("row%0d_linear", i), int'(dut.linear), tbl[i].exp_lin);
         chk($sformatf("row%0d_length", i), int'(dut.length), tbl[i].exp_len);
      end

      // Write lands on a half+quarter tick: load wins, quarter sees old reload flag.
      repeat (3) tick();
      reg400B = 8'h08;
      tick();
      chk("collide_length", int'(dut.length), 254);
      chk("collide_linear", int'(dut.linear), 63);
      repeat (4) tick();
      chk("post_write_reload", int'(dut.linear), 72);

      // Period 1: ultrasonic case.
      reg4008 = 8'hC8;
      reg400A = 8'h01;
      repeat (3) tick();
`ifdef TRIANGLE_ULTRASONIC_MUTE_EN
      chk("p1_wave_a", int'(wave), 2);
`else
      chk("p1_wave_a", int'(wave), 0);
`endif
      repeat (8) tick();
`ifdef TRIANGLE_ULTRASONIC_MUTE_EN
      chk("p1_wave_b", int'(wave), 2);
`else
      chk("p1_wave_b", int'(wave), 3);
`endif

      // Asynchronous reset mid-cycle takes effect before the next edge.
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_wave", int'(wave), 15);
      chk("async_reset_step", int'(dut.step), 0);
      chk("async_reset_length", int'(dut.length), 0);
      tick();
      rst_n = 1'b1;

      // Random register traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 11) == 0) begin
            case ($urandom_range(0, 3))
               0: reg4008 = 8'($urandom);
               1: reg400A = 8'($urandom_range(0, 7));
               2: reg400B = {5'($urandom_range(0, 31)), 3'b000};
               default: reg400A = 8'($urandom_range(0, 40));
            endcase
         end
         if ($urandom_range(0, 599) == 0) begin
            #2 rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end else begin
            tick();
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
